// File: rtl/step_profile_scheduler_if.sv
// Start/mode request in; pulse-generator period/enable and display status out.
// The scheduler side uses master; the requesting/consuming side uses slave.
interface step_profile_scheduler_if #(
    parameter int PW = 28
);
    logic          start;
    logic [1:0]    mode;
    logic [PW-1:0] half_period;
    logic          period_load;
    logic          gen_enable;
    logic [8:0]    sec_count;
    logic          done;
    logic          busy;

    modport master (
        input  start, mode,
        output half_period, period_load, gen_enable, sec_count, done, busy
    );

    modport slave (
        output start, mode,
        input  half_period, period_load, gen_enable, sec_count, done, busy
    );
endinterface

// File: rtl/step_profile_scheduler.sv
// Picks pulse-generator half-period/enable from mode, stepping a 144 s pace profile in hybrid mode; start->enable 1 cycle.
// No backpressure: outputs are registered levels plus a one-cycle period_load strobe the generator must take.
module step_profile_scheduler #(
    parameter int SEC_CYCLES  = 100000000,
    parameter int PROFILE_LEN = 144,
    parameter int PW          = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    step_profile_scheduler_if.master bus
);
    localparam int             PSW      = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
    localparam logic [PSW-1:0] PS_TC    = PSW'(SEC_CYCLES - 1);
    localparam logic [8:0]     SEC_LAST = 9'(PROFILE_LEN - 1);
    localparam logic [8:0]     SEC_END  = 9'(PROFILE_LEN);

    typedef enum logic [1:0] {IDLE, FIXED, PROFILE, DONE} state_t;

    state_t         state_q, state_n;
    logic [1:0]     mode_q, mode_n;
    logic [PSW-1:0] presc_q, presc_n;
    logic [8:0]     sec_q, sec_n;
    logic [PW-1:0]  hp_q, hp_n;
    logic           load_q, load_n;
    logic           en_q, en_n;
    logic           done_q, done_n;

    function automatic logic [PW-1:0] fixed_hp(input logic [1:0] m);
        case (m)
            2'd0:    return PW'(1520000);
            2'd1:    return PW'(775193);
            default: return PW'(389205);
        endcase
    endfunction

    function automatic logic [PW-1:0] profile_hp(input logic [8:0] s);
        logic [PW-1:0] v;
        if (s >= 9'd78)      v = PW'(401606);
        else if (s >= 9'd73) v = PW'(1449275);
        else if (s >= 9'd9)  v = PW'(719424);
        else begin
            case (s[3:0])
                4'd0:    v = PW'(2439024);
                4'd1:    v = PW'(1492537);
                4'd2:    v = PW'(751879);
                4'd3:    v = PW'(1818181);
                4'd4:    v = PW'(709219);
                4'd5:    v = PW'(1639344);
                4'd6:    v = PW'(2564102);
                4'd7:    v = PW'(1639344);
                default: v = PW'(1492537);
            endcase
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] entry_hp(input logic [1:0] m);
        return (m == 2'd3) ? profile_hp(9'd0) : fixed_hp(m);
    endfunction

    always_comb begin
        state_n = state_q;
        mode_n  = mode_q;
        presc_n = presc_q;
        sec_n   = sec_q;
        hp_n    = hp_q;
        load_n  = 1'b0;
        en_n    = en_q;
        done_n  = done_q;

        // Stop dominates everything, including a pending terminal tick.
        if (!bus.start) begin
            state_n = IDLE;
            presc_n = '0;
            sec_n   = '0;
            hp_n    = '0;
            en_n    = 1'b0;
            done_n  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_n = (bus.mode == 2'd3) ? PROFILE : FIXED;
                    mode_n  = bus.mode;
                    presc_n = '0;
                    sec_n   = '0;
                    hp_n    = entry_hp(bus.mode);
                    load_n  = 1'b1;
                    en_n    = 1'b1;
                    done_n  = 1'b0;
                end
                FIXED, PROFILE: begin
                    if (bus.mode != mode_q) begin
                        // Mode change restarts from second 0 and beats a coincident tick.
                        state_n = (bus.mode == 2'd3) ? PROFILE : FIXED;
                        mode_n  = bus.mode;
                        presc_n = '0;
                        sec_n   = '0;
                        hp_n    = entry_hp(bus.mode);
                        load_n  = 1'b1;
                        en_n    = 1'b1;
                    end else if (state_q == PROFILE) begin
                        if (presc_q == PS_TC) begin
                            presc_n = '0;
                            if (sec_q == SEC_LAST) begin
                                state_n = DONE;
                                sec_n   = SEC_END;
                                hp_n    = '0;
                                en_n    = 1'b0;
                                done_n  = 1'b1;
                            end else begin
                                sec_n  = sec_q + 9'd1;
                                hp_n   = profile_hp(sec_q + 9'd1);
                                load_n = (hp_n != hp_q);
                            end
                        end else begin
                            presc_n = presc_q + PSW'(1);
                        end
                    end
                end
                DONE: begin
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            presc_q <= '0;
            sec_q   <= '0;
            hp_q    <= '0;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            presc_q <= presc_n;
            sec_q   <= sec_n;
            hp_q    <= hp_n;
            load_q  <= load_n;
            en_q    <= en_n;
            done_q  <= done_n;
        end
    end

    assign bus.half_period = hp_q;
    assign bus.period_load = load_q;
    assign bus.gen_enable  = en_q;
    assign bus.sec_count   = sec_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q == FIXED) || (state_q == PROFILE);
endmodule

// File: tb/tb_step_profile_scheduler.sv
// Bench for step_profile_scheduler with a 10-cycle second; expected half-periods are queued at stimulus time
// and popped whenever the DUT strobes period_load.
module tb_step_profile_scheduler;
    localparam int SEC  = 10;
    localparam int PLEN = 144;
    localparam int PW   = 28;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [PW-1:0] sb[$];

    step_profile_scheduler_if #(.PW(PW)) bus ();

    step_profile_scheduler #(
        .SEC_CYCLES (SEC),
        .PROFILE_LEN(PLEN),
        .PW         (PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] exp_hp(input int s);
        case (s)
            0: return PW'(2439024);
            1: return PW'(1492537);
            2: return PW'(751879);
            3: return PW'(1818181);
            4: return PW'(709219);
            5: return PW'(1639344);
            6: return PW'(2564102);
            7: return PW'(1639344);
            8: return PW'(1492537);
            9: return PW'(719424);
            default: begin
                if (s <= 72)      return PW'(719424);
                else if (s <= 77) return PW'(1449275);
                else              return PW'(401606);
            end
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance a running profile from second from_s to to_s, queueing each expected strobe.
    task automatic run_seconds(input int from_s, input int to_s);
        for (int s = from_s + 1; s <= to_s; s++) begin
            if (exp_hp(s) != exp_hp(s - 1)) sb.push_back(exp_hp(s));
            repeat (SEC) tick();
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.period_load) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_strobe half_period=%0d, none expected", bus.half_period);
            end else begin
                logic [PW-1:0] e;
                e = sb.pop_front();
                if (bus.half_period !== e) begin
                    n_fail++;
                    $display("FAIL sb_half_period got %0d want %0d", bus.half_period, e);
                end
            end
        end
    end

    task automatic test_reset;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        reset     = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({bus.half_period, bus.period_load, bus.gen_enable, bus.sec_count, bus.done, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs hp=%0d pl=%b en=%b sec=%0d done=%b busy=%b want all 0",
                     bus.half_period, bus.period_load, bus.gen_enable, bus.sec_count, bus.done, bus.busy);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fixed;
        for (int m = 0; m < 3; m++) begin
            logic [PW-1:0] want;
            want = (m == 0) ? PW'(1520000) : (m == 1) ? PW'(775193) : PW'(389205);
            bus.mode  = 2'(m);
            bus.start = 1'b1;
            sb.push_back(want);
            tick();
            n_cmp++;
            if ({bus.gen_enable, bus.period_load, bus.busy, bus.half_period, bus.sec_count} !== {3'b111, want, 9'd0}) begin
                n_fail++;
                $display("FAIL fixed_entry m=%0d en=%b pl=%b busy=%b hp=%0d sec=%0d want 1 1 1 %0d 0",
                         m, bus.gen_enable, bus.period_load, bus.busy, bus.half_period, bus.sec_count, want);
            end
            tick();
            n_cmp++;
            if (bus.period_load !== 1'b0 || bus.half_period !== want) begin
                n_fail++;
                $display("FAIL fixed_strobe_width m=%0d pl=%b hp=%0d want 0 %0d", m, bus.period_load, bus.half_period, want);
            end
            if (m == 1) begin
                for (int c = 0; c < 50; c++) begin
                    tick();
                    n_cmp++;
                    if (bus.sec_count !== 9'd0 || bus.gen_enable !== 1'b1) begin
                        n_fail++;
                        $display("FAIL fixed_hold c=%0d sec=%0d en=%b want 0 1", c, bus.sec_count, bus.gen_enable);
                    end
                end
            end
            bus.start = 1'b0;
            tick();
            n_cmp++;
            if ({bus.gen_enable, bus.busy, bus.half_period, bus.done} !== '0) begin
                n_fail++;
                $display("FAIL fixed_stop m=%0d en=%b busy=%b hp=%0d done=%b want 0", m,
                         bus.gen_enable, bus.busy, bus.half_period, bus.done);
            end
        end
    endtask

    task automatic test_profile;
        bus.mode  = 2'd3;
        bus.start = 1'b1;
        sb.push_back(exp_hp(0));
        tick();
        n_cmp++;
        if (bus.half_period !== exp_hp(0) || bus.period_load !== 1'b1 || bus.sec_count !== 9'd0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL profile_entry hp=%0d pl=%b sec=%0d busy=%b want %0d 1 0 1",
                     bus.half_period, bus.period_load, bus.sec_count, bus.busy, exp_hp(0));
        end
        for (int s = 1; s < PLEN; s++) begin
            logic chg;
            chg = (exp_hp(s) != exp_hp(s - 1));
            if (chg) sb.push_back(exp_hp(s));
            repeat (SEC - 1) tick();
            n_cmp++;
            if (bus.sec_count !== 9'(s - 1)) begin
                n_fail++;
                $display("FAIL profile_early s=%0d sec=%0d want %0d", s, bus.sec_count, s - 1);
            end
            tick();
            n_cmp++;
            if (bus.sec_count !== 9'(s) || bus.half_period !== exp_hp(s) || bus.period_load !== chg) begin
                n_fail++;
                $display("FAIL profile_second s=%0d sec=%0d hp=%0d pl=%b want %0d %0d %b",
                         s, bus.sec_count, bus.half_period, bus.period_load, s, exp_hp(s), chg);
            end
        end
        repeat (SEC) tick();
        n_cmp++;
        if ({bus.done, bus.gen_enable, bus.busy, bus.period_load, bus.half_period, bus.sec_count} !==
            {4'b1000, {PW{1'b0}}, 9'(PLEN)}) begin
            n_fail++;
            $display("FAIL profile_done done=%b en=%b busy=%b pl=%b hp=%0d sec=%0d want 1 0 0 0 0 %0d",
                     bus.done, bus.gen_enable, bus.busy, bus.period_load, bus.half_period, bus.sec_count, PLEN);
        end
        bus.mode = 2'd1;
        for (int c = 0; c < 100; c++) begin
            tick();
            n_cmp++;
            if (bus.done !== 1'b1 || bus.sec_count !== 9'(PLEN) || bus.gen_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL done_hold c=%0d done=%b sec=%0d en=%b want 1 %0d 0",
                         c, bus.done, bus.sec_count, bus.gen_enable, PLEN);
            end
        end
        bus.start = 1'b0;
        tick();
        n_cmp++;
        if ({bus.done, bus.sec_count, bus.busy, bus.gen_enable} !== '0) begin
            n_fail++;
            $display("FAIL done_exit done=%b sec=%0d busy=%b en=%b want 0",
                     bus.done, bus.sec_count, bus.busy, bus.gen_enable);
        end
    endtask

    task automatic test_mode_change;
        bus.mode  = 2'd3;
        bus.start = 1'b1;
        sb.push_back(exp_hp(0));
        tick();
        run_seconds(0, 20);
        n_cmp++;
        if (bus.sec_count !== 9'd20) begin
            n_fail++;
            $display("FAIL mode_chg_pre sec=%0d want 20", bus.sec_count);
        end
        bus.mode = 2'd2;
        sb.push_back(PW'(389205));
        tick();
        n_cmp++;
        if ({bus.sec_count, bus.half_period, bus.period_load, bus.busy, bus.gen_enable} !== {9'd0, PW'(389205), 3'b111}) begin
            n_fail++;
            $display("FAIL mode_chg sec=%0d hp=%0d pl=%b busy=%b en=%b want 0 389205 1 1 1",
                     bus.sec_count, bus.half_period, bus.period_load, bus.busy, bus.gen_enable);
        end
        bus.start = 1'b0;
        tick();
        // Mode change coinciding with the terminal tick at second 5.
        bus.mode  = 2'd3;
        bus.start = 1'b1;
        sb.push_back(exp_hp(0));
        tick();
        run_seconds(0, 5);
        repeat (SEC - 1) tick();
        bus.mode = 2'd0;
        sb.push_back(PW'(1520000));
        tick();
        n_cmp++;
        if (bus.sec_count !== 9'd0 || bus.half_period !== PW'(1520000) || bus.period_load !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_chg_on_tick sec=%0d hp=%0d pl=%b want 0 1520000 1",
                     bus.sec_count, bus.half_period, bus.period_load);
        end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_stop_on_tick;
        bus.mode  = 2'd3;
        bus.start = 1'b1;
        sb.push_back(exp_hp(0));
        tick();
        run_seconds(0, 30);
        repeat (SEC - 1) tick();
        bus.start = 1'b0;
        tick();
        n_cmp++;
        if ({bus.busy, bus.sec_count, bus.gen_enable, bus.half_period, bus.period_load} !== '0) begin
            n_fail++;
            $display("FAIL stop_on_tick busy=%b sec=%0d en=%b hp=%0d pl=%b want 0",
                     bus.busy, bus.sec_count, bus.gen_enable, bus.half_period, bus.period_load);
        end
        tick();
        n_cmp++;
        if (bus.sec_count !== 9'd0) begin
            n_fail++;
            $display("FAIL stop_on_tick_hold sec=%0d want 0", bus.sec_count);
        end
    endtask

    task automatic test_reset_midprofile;
        bus.mode  = 2'd3;
        bus.start = 1'b1;
        sb.push_back(exp_hp(0));
        tick();
        run_seconds(0, 5);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.half_period, bus.period_load, bus.gen_enable, bus.sec_count, bus.done, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset hp=%0d pl=%b en=%b sec=%0d done=%b busy=%b want all 0",
                     bus.half_period, bus.period_load, bus.gen_enable, bus.sec_count, bus.done, bus.busy);
        end
        #2 reset = 1'b1;
        sb.push_back(exp_hp(0));
        tick();
        n_cmp++;
        if (bus.half_period !== exp_hp(0) || bus.period_load !== 1'b1 || bus.sec_count !== 9'd0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_restart hp=%0d pl=%b sec=%0d busy=%b want %0d 1 0 1",
                     bus.half_period, bus.period_load, bus.sec_count, bus.busy, exp_hp(0));
        end
        bus.start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_profile();
        test_mode_change();
        test_stop_on_tick();
        test_reset_midprofile();
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained pending=%0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
